// File: rtl/shift_serializer_pkg.sv
// Shared definitions for the shift serializer: FSM state encodings and parameter defaults.
package shift_serializer_pkg;

    localparam int DEFAULT_BITS     = 8;
    localparam int DEFAULT_TICK_DIV = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_serializer_tick_div.sv
// Bit-period prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick on the last count.
module module_tick_div
    import shift_serializer_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic btn_reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    // A one-cycle bit period still needs a 1-bit counter that simply stays at zero.
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/shift_serializer.sv
// Parallel-to-serial shifter: accepts a word when idle (load_valid & load_ready), sends one bit
// every TICK_DIV cycles in the captured order, then pulses done for one cycle.
module shift_serializer
    import shift_serializer_pkg::*;
#(
    parameter int BITS     = DEFAULT_BITS,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic            clk,
    input  logic            btn_reset,
    input  logic            load_valid,
    input  logic [BITS-1:0] load_data,
    input  logic            load_msb_first,
    input  logic            fill_bit,
    output logic            load_ready,
    output logic            ser_data,
    output logic            ser_strobe,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] leds,
    output state_t          fsm_state
);

    localparam int BW = $clog2(BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(BITS - 1);

    state_t          state_q, state_d;
    logic [BITS-1:0] shreg;
    logic [BW-1:0]   bit_cnt;
    logic            msb_q, fill_q;
    logic            tick, accept, strobe;

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (tick && (bit_cnt == LAST_BIT)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = load_valid & load_ready;
    assign strobe = busy & tick;

    module_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .clk       (clk),
        .btn_reset (btn_reset),
        .enable    (busy),
        .clear     (accept),
        .tick      (tick)
    );

    // Word options are latched on accept so input changes mid-word cannot disturb the stream.
    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            msb_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else if (accept) begin
            shreg   <= load_data;
            bit_cnt <= '0;
            msb_q   <= load_msb_first;
            fill_q  <= fill_bit;
        end else if (strobe) begin
            shreg   <= msb_q ? {shreg[BITS-2:0], fill_q} : {fill_q, shreg[BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign ser_strobe = strobe;
    assign ser_data   = strobe & (msb_q ? shreg[BITS-1] : shreg[0]);
    assign leds       = shreg;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: a TICK_DIV=1 and a TICK_DIV=4 instance, directed vector table,
// mid-word reset sequence and randomized words checked cycle by cycle against a word-level model.
module tb_shift_serializer;
    import shift_serializer_pkg::*;

    localparam int BITS = 8;

    typedef struct {
        logic       sel;
        logic [7:0] word;
        logic       msb;
        logic       fill;
        logic       glitch;
        logic       hold;
        logic [7:0] exp_stream;
        logic [7:0] exp_leds;
    } vec_t;

    logic       clk = 1'b0;
    logic       btn_reset;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_msb_first;
    logic       fill_bit;
    logic       sel;

    logic       lv1, rdy1, dat1, stb1, busy1, done1;
    logic       lv4, rdy4, dat4, stb4, busy4, done4;
    logic [7:0] leds1, leds4;
    state_t     st1, st4;

    logic       m_ready, m_data, m_strobe, m_busy, m_done;
    logic [7:0] m_leds;
    state_t     m_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign lv1 = load_valid & ~sel;
    assign lv4 = load_valid & sel;

    shift_serializer #(.BITS(BITS), .TICK_DIV(1)) dut1 (
        .clk(clk), .btn_reset(btn_reset), .load_valid(lv1), .load_data(load_data),
        .load_msb_first(load_msb_first), .fill_bit(fill_bit), .load_ready(rdy1),
        .ser_data(dat1), .ser_strobe(stb1), .busy(busy1), .done(done1), .leds(leds1),
        .fsm_state(st1)
    );

    shift_serializer #(.BITS(BITS), .TICK_DIV(4)) dut4 (
        .clk(clk), .btn_reset(btn_reset), .load_valid(lv4), .load_data(load_data),
        .load_msb_first(load_msb_first), .fill_bit(fill_bit), .load_ready(rdy4),
        .ser_data(dat4), .ser_strobe(stb4), .busy(busy4), .done(done4), .leds(leds4),
        .fsm_state(st4)
    );

    always_comb begin
        m_ready  = sel ? rdy4  : rdy1;
        m_data   = sel ? dat4  : dat1;
        m_strobe = sel ? stb4  : stb1;
        m_busy   = sel ? busy4 : busy1;
        m_done   = sel ? done4 : done1;
        m_leds   = sel ? leds4 : leds1;
        m_state  = sel ? st4   : st1;
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s (tick_div=%0d): got %0h expected %0h at %0t",
                     name, sel ? 4 : 1, got, exp, $time);
        end
    endtask

    // Register image after s bits have left: vacated positions hold the fill value.
    function automatic logic [7:0] model_leds(logic [7:0] w, logic msb, logic fill, int s);
        logic [7:0] r;
        int src;
        for (int i = 0; i < BITS; i++) begin
            src  = msb ? i - s : i + s;
            r[i] = (src >= 0 && src < BITS) ? w[src] : fill;
        end
        return r;
    endfunction

    function automatic logic model_bit(logic [7:0] w, logic msb, int k);
        return msb ? w[BITS-1-k] : w[k];
    endfunction

    function automatic logic [7:0] model_stream(logic [7:0] w, logic msb);
        logic [7:0] r;
        for (int k = 0; k < BITS; k++) r[k] = model_bit(w, msb, k);
        return r;
    endfunction

    task automatic check_reset_values();
        chk("rst_load_ready", int'(m_ready), 1);
        chk("rst_ser_strobe", int'(m_strobe), 0);
        chk("rst_ser_data",   int'(m_data), 0);
        chk("rst_busy",       int'(m_busy), 0);
        chk("rst_done",       int'(m_done), 0);
        chk("rst_leds",       int'(m_leds), 0);
        chk("rst_state",      int'(m_state), int'(IDLE));
    endtask

    // Cycle n counts from the accept edge (n = 1 is the first cycle after it).
    task automatic check_cycle(int n, int t, logic [7:0] w, logic msb, logic fill);
        int  total;
        int  sent;
        logic exp_strb;
        total    = BITS * t;
        exp_strb = (n % t == 0) && (n <= total);
        sent     = (n - 1) / t;
        if (sent > BITS) sent = BITS;
        chk("ser_strobe", int'(m_strobe), int'(exp_strb));
        if (exp_strb) chk("ser_data", int'(m_data), int'(model_bit(w, msb, n / t - 1)));
        chk("busy",       int'(m_busy), int'(n <= total));
        chk("done",       int'(m_done), int'(n == total + 1));
        chk("load_ready", int'(m_ready), 0);
        chk("leds",       int'(m_leds), int'(model_leds(w, msb, fill, sent)));
    endtask

    task automatic run_word(input logic s, input logic [7:0] w, input logic msb,
                            input logic fill, input logic glitch, input logic hold,
                            output logic [7:0] got_stream, output logic [7:0] got_leds);
        int t;
        int total;
        int nstrb;
        sel            = s;
        t              = s ? 4 : 1;
        total          = BITS * t;
        load_valid     = 1'b1;
        load_data      = w;
        load_msb_first = msb;
        fill_bit       = fill;
        @(posedge clk); #1;
        got_stream = '0;
        nstrb      = 0;
        for (int n = 1; n <= total + 1; n++) begin
            load_valid     = hold || (glitch && (n == 3 || n == total + 1));
            load_data      = (glitch && load_valid) ? 8'hFF : 8'($urandom);
            load_msb_first = 1'($urandom);
            fill_bit       = 1'($urandom);
            @(negedge clk);
            check_cycle(n, t, w, msb, fill);
            if (m_strobe) begin
                if (nstrb < BITS) got_stream[nstrb] = m_data;
                nstrb++;
            end
            @(posedge clk); #1;
        end
        load_valid = hold;
        @(negedge clk);
        chk("strobe_count",    nstrb, BITS);
        chk("idle_load_ready", int'(m_ready), 1);
        chk("idle_busy",       int'(m_busy), 0);
        chk("idle_strobe",     int'(m_strobe), 0);
        chk("idle_leds",       int'(m_leds), int'(model_leds(w, msb, fill, BITS)));
        got_leds = m_leds;
    endtask

    task automatic reset_mid_word(input logic s, input logic [7:0] w);
        int t;
        sel            = s;
        t              = s ? 4 : 1;
        load_valid     = 1'b1;
        load_data      = w;
        load_msb_first = 1'b1;
        fill_bit       = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (3 * t) @(posedge clk);
        #2;
        btn_reset = 1'b0;
        #1;
        check_reset_values();
        repeat (3) begin
            @(negedge clk);
            chk("abort_done",   int'(m_done), 0);
            chk("abort_strobe", int'(m_strobe), 0);
        end
        btn_reset = 1'b1;
    endtask

    vec_t       vecs[6];
    logic [7:0] got_stream, got_leds;
    logic       r_sel, r_msb, r_fill, r_glitch;
    logic [7:0] r_word;

    initial begin
        vecs[0] = '{1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00};
        vecs[1] = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'hFF};
        vecs[2] = '{1'b1, 8'hA0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00};
        vecs[3] = '{1'b1, 8'h96, 1'b1, 1'b1, 1'b1, 1'b0, 8'h69, 8'hFF};
        vecs[4] = '{1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 8'h00};
        vecs[5] = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00};

        btn_reset      = 1'b0;
        load_valid     = 1'b0;
        load_data      = 8'h5A;
        load_msb_first = 1'b0;
        fill_bit       = 1'b1;
        sel            = 1'b0;
        repeat (2) @(negedge clk);
        sel = 1'b0;
        #1 check_reset_values();
        sel = 1'b1;
        #1 check_reset_values();
        @(negedge clk);
        btn_reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_word(vecs[i].sel, vecs[i].word, vecs[i].msb, vecs[i].fill,
                     vecs[i].glitch, vecs[i].hold, got_stream, got_leds);
            chk("vec_stream", int'(got_stream), int'(vecs[i].exp_stream));
            chk("vec_leds",   int'(got_leds),   int'(vecs[i].exp_leds));
        end

        reset_mid_word(1'b0, 8'hB7);
        run_word(1'b0, 8'h6D, 1'b0, 1'b0, 1'b0, 1'b0, got_stream, got_leds);
        chk("post_reset_stream", int'(got_stream), int'(model_stream(8'h6D, 1'b0)));
        reset_mid_word(1'b1, 8'h4E);
        run_word(1'b1, 8'hD2, 1'b1, 1'b1, 1'b0, 1'b0, got_stream, got_leds);
        chk("post_reset_stream", int'(got_stream), int'(model_stream(8'hD2, 1'b1)));

        repeat (20) begin
            r_sel    = 1'($urandom_range(0, 1));
            r_word   = 8'($urandom);
            r_msb    = 1'($urandom_range(0, 1));
            r_fill   = 1'($urandom_range(0, 1));
            r_glitch = 1'($urandom_range(0, 1));
            run_word(r_sel, r_word, r_msb, r_fill, r_glitch, 1'b0, got_stream, got_leds);
            chk("rand_stream", int'(got_stream), int'(model_stream(r_word, r_msb)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_serializer.md
SHIFT_SERIALIZER -- requirements
Module: shift_serializer

Interface
REQ-001 Parameter BITS, 8, width of the parallel word; legal range BITS >= 2.
REQ-002 Parameter TICK_DIV, 4, clock cycles per serial bit; legal range TICK_DIV >= 1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 btn_reset  input  1  reset, asynchronous, active-low.
REQ-005 load_valid  input  1  a parallel word is offered this cycle.
REQ-006 load_data  input  BITS  word to serialize; sampled only on accept.
REQ-007 load_msb_first  input  1  1 = MSB first, 0 = LSB first; sampled only on accept.
REQ-008 fill_bit  input  1  value shifted into each vacated position; sampled only on accept.
REQ-009 load_ready  output  1  block can accept a word this cycle.
REQ-010 ser_data  output  1  outgoing bit; meaningful only while ser_strobe = 1.
REQ-011 ser_strobe  output  1  one-cycle pulse per transmitted bit.
REQ-012 busy  output  1  high while a word is being serialized.
REQ-013 done  output  1  one-cycle pulse after the last bit.
REQ-014 leds  output  BITS  live contents of the internal shift register.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE, load_ready SHALL be 1; in SHIFT and DONE, load_ready SHALL be 0.
REQ-017 Accept SHALL occur on a clock edge with load_valid & load_ready: capture load_data, load_msb_first and fill_bit, clear the tick and bit counters, and enter SHIFT.
REQ-018 busy SHALL be 1 exactly while the state is SHIFT.
REQ-019 In SHIFT, the tick counter SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-020 ser_strobe SHALL be 1 in each SHIFT cycle with tick counter = TICK_DIV-1, giving strobe k (k = 0..BITS-1) in cycle (k+1)*TICK_DIV after the accept edge.
REQ-021 While ser_strobe = 1, ser_data SHALL equal register[BITS-1] if MSB first, else register[0].
REQ-022 On each strobe edge, the register SHALL shift away the sent bit and insert the captured fill_bit at the opposite end.
REQ-023 On each strobe edge, the bit counter SHALL increment.
REQ-024 On the strobe edge with bit counter = BITS-1, the FSM SHALL enter DONE.
REQ-025 DONE SHALL last exactly one cycle, with done = 1, then return to IDLE.
REQ-026 load_valid SHALL be ignored when load_ready = 0, including in the DONE cycle, with no capture and no effect.
REQ-027 After completion, leds SHALL hold the all-fill_bit pattern until the next accept.
REQ-028 On accept, leds SHALL show load_data from the cycle after the accept edge.
REQ-029 Changes on load_data, load_msb_first or fill_bit during SHIFT SHALL have no effect.
REQ-030 load_valid held high continuously SHALL yield back-to-back words with exactly one IDLE cycle between done and the next accept.

Reset
REQ-031 While btn_reset = 0, the block SHALL be in IDLE, with the register and both counters at 0.
REQ-032 Reset values SHALL be: load_ready = 1, ser_strobe = 0, ser_data = 0, busy = 0, done = 0, leds = 0.
REQ-033 Reset asserted mid-word SHALL abort immediately, with no further strobes and no done pulse.
REQ-034 After reset release, the block SHALL accept on the first clock edge that has load_valid = 1.

Structure
REQ-035 A shared package SHALL hold the FSM state encodings (IDLE = 0, SHIFT = 1, DONE = 2, 2 bits) and the BITS/TICK_DIV defaults.
REQ-036 The tick prescaler SHALL be the sub-module module_tick_div (parameter TICK_DIV; ports clk, btn_reset, enable, clear, tick); all other logic SHALL reside in shift_serializer.

Verification
REQ-037 BITS=8, TICK_DIV=1, load 8'h01, MSB first, fill 0 -> ser_data 0,0,0,0,0,0,0,1 on strobes in cycles 1..8 after accept; done in cycle 9; leds = 8'h00.
REQ-038 BITS=8, TICK_DIV=1, load 8'h01, LSB first, fill 1 -> ser_data 1,0,0,0,0,0,0,0; leds end at 8'hFF; load_ready high in cycle 10.
REQ-039 TICK_DIV=4, load 8'hA0, MSB first -> strobes in cycles 4, 8, ..., 32 only; ser_data 1,0,1,0,0,0,0,0; busy high in cycles 1..32.
REQ-040 Pulse load_valid with 8'hFF in cycle 3 of a word and in its DONE cycle -> both ignored; the original word completes unchanged.
REQ-041 Assert btn_reset = 0 after the 3rd strobe -> same-cycle return to reset values, no done pulse; the next accept serializes correctly.
REQ-042 Hold load_valid = 1 with 8'hC3 then 8'h3C -> two complete words, with exactly one IDLE cycle between the done pulse and the second accept.
